// File: rtl/mainfsm_hs.sv
// Multicycle main control FSM with memory ready handshake, stall timeout and sticky fault.
// Optional branch-with-link path enabled by defining MAINFSM_BL_EN.
module mainfsm_hs #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       LinkW,
  output logic       fault,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_UNKNOWN  = 4'd10;
  localparam logic [3:0] S_BRANCHL  = 4'd11;
  localparam logic [3:0] S_FAULT    = 4'd12;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [3:0]       state_r;
  logic [3:0]       next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_next_s;
  logic             mem_state_s;
  logic             timeout_s;
  logic             unused_s;

  assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  // A ready in the timeout cycle still completes the access normally.
  assign timeout_s   = (TIMEOUT_CYCLES != 32'sd0) && (wait_cnt_r == TIMEOUT_V) && !mem_ready;
  assign state_o     = state_r;
  assign fault       = (state_r == S_FAULT);
  assign unused_s    = ^Funct[4:1];

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready)      next_state_s = S_DECODE;
        else if (timeout_s) next_state_s = S_FAULT;
        else                next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          2'b00: begin
            if (Funct[5]) next_state_s = S_EXECUTEI;
            else          next_state_s = S_EXECUTER;
          end
          2'b01: next_state_s = S_MEMADR;
          2'b10: begin
`ifdef MAINFSM_BL_EN
            if (Funct[4]) next_state_s = S_BRANCHL;
            else          next_state_s = S_BRANCH;
`else
            next_state_s = S_BRANCH;
`endif
          end
          default: next_state_s = S_UNKNOWN;
        endcase
      end
      S_EXECUTER, S_EXECUTEI: next_state_s = S_ALUWB;
      S_ALUWB:                next_state_s = S_FETCH;
      S_MEMADR: begin
        if (Funct[0]) next_state_s = S_MEMRD;
        else          next_state_s = S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready)      next_state_s = S_MEMWB;
        else if (timeout_s) next_state_s = S_FAULT;
        else                next_state_s = S_MEMRD;
      end
      S_MEMWB: next_state_s = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)      next_state_s = S_FETCH;
        else if (timeout_s) next_state_s = S_FAULT;
        else                next_state_s = S_MEMWR;
      end
      S_BRANCH, S_BRANCHL, S_UNKNOWN: next_state_s = S_FETCH;
      S_FAULT:                        next_state_s = S_FAULT;
      default:                        next_state_s = S_FETCH;
    endcase
  end

  // Wait counter: counts only while stalled in a memory state, zero otherwise
  always_comb begin
    wait_cnt_next_s = {CNT_W{1'b0}};
    if (mem_state_s && !mem_ready && (next_state_s == state_r)) begin
      if (wait_cnt_r != CNT_MAX) wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
      else                       wait_cnt_next_s = wait_cnt_r;
    end else begin
      wait_cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // Moore output decode; FETCH strobes are gated by ready and by reset
  always_comb begin
    mem_req   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    LinkW     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (reset_n) begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
          NextPC  = mem_ready;
        end else begin
          mem_req = 1'b0;
          IRWrite = 1'b0;
          NextPC  = 1'b0;
        end
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB:  RegW = 1'b1;
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD: begin
        mem_req = reset_n;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
      end
      S_MEMWR: begin
        mem_req = reset_n;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      S_BRANCHL: begin
        Branch    = 1'b1;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        RegW      = 1'b1;
`ifdef MAINFSM_BL_EN
        LinkW     = 1'b1;
`endif
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mainfsm_hs.sv
// Directed bench for mainfsm_hs: instruction flows, wait states, timeout fault and reset.
module tb_mainfsm_hs;
  logic       clk;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       mem_req, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, LinkW, fault;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state_o;
  int         checks;
  int         errors;
  logic [31:0] all_outs;

  mainfsm_hs dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .LinkW(LinkW), .fault(fault),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_outs();
    all_outs = {14'd0, mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                NextPC, RegW, MemW, Branch, ALUOp, LinkW, fault};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; Op = 2'b00; Funct = 6'b000000; mem_ready = 1'b1;
    #12;
    check_eq("rst_state", {28'd0, state_o}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_irwrite", {31'd0, IRWrite}, 32'd0);
    check_eq("rst_nextpc", {31'd0, NextPC}, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check_eq("rel_mem_req", {31'd0, mem_req}, 32'd1);

    // T1: ADD register form
    check_eq("t1_c1_irwrite", {31'd0, IRWrite}, 32'd1);
    check_eq("t1_c1_nextpc", {31'd0, NextPC}, 32'd1);
    check_eq("t1_c1_regw", {31'd0, RegW}, 32'd0);
    step();
    check_eq("t1_c2_state", {28'd0, state_o}, 32'd1);
    check_eq("t1_c2_irwrite", {31'd0, IRWrite}, 32'd0);
    check_eq("t1_c2_regw", {31'd0, RegW}, 32'd0);
    step();
    check_eq("t1_c3_state", {28'd0, state_o}, 32'd6);
    check_eq("t1_c3_aluop", {31'd0, ALUOp}, 32'd1);
    check_eq("t1_c3_regw", {31'd0, RegW}, 32'd0);
    step();
    check_eq("t1_c4_state", {28'd0, state_o}, 32'd8);
    check_eq("t1_c4_regw", {31'd0, RegW}, 32'd1);
    check_eq("t1_c4_irwrite", {31'd0, IRWrite}, 32'd0);
    step();
    check_eq("t1_back_fetch", {28'd0, state_o}, 32'd0);
    check_eq("t1_c5_regw", {31'd0, RegW}, 32'd0);

    // T2: LDR with three wait states in MEMRD
    Op = 2'b01; Funct = 6'b000001;
    step();
    check_eq("t2_decode", {28'd0, state_o}, 32'd1);
    step();
    check_eq("t2_memadr", {28'd0, state_o}, 32'd2);
    check_eq("t2_memadr_srcb", {30'd0, ALUSrcB}, 32'd1);
    mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) step();
      else step();
      check_eq("t2_memrd_state", {28'd0, state_o}, 32'd3);
      check_eq("t2_memrd_adrsrc", {31'd0, AdrSrc}, 32'd1);
      check_eq("t2_memrd_req", {31'd0, mem_req}, 32'd1);
      if (i == 4) mem_ready = 1'b1;
      else mem_ready = 1'b0;
    end
    step();
    check_eq("t2_memwb_state", {28'd0, state_o}, 32'd4);
    check_eq("t2_memwb_result", {30'd0, ResultSrc}, 32'd1);
    check_eq("t2_memwb_regw", {31'd0, RegW}, 32'd1);
    step();
    check_eq("t2_back_fetch", {28'd0, state_o}, 32'd0);

    // T4: branch with link bit set
    Op = 2'b10; Funct = 6'b010000;
    step();
    step();
`ifdef MAINFSM_BL_EN
    check_eq("t4_state", {28'd0, state_o}, 32'd11);
    check_eq("t4_linkw", {31'd0, LinkW}, 32'd1);
    check_eq("t4_regw", {31'd0, RegW}, 32'd1);
`else
    check_eq("t4_state", {28'd0, state_o}, 32'd9);
    check_eq("t4_linkw", {31'd0, LinkW}, 32'd0);
    check_eq("t4_regw", {31'd0, RegW}, 32'd0);
`endif
    check_eq("t4_branch", {31'd0, Branch}, 32'd1);
    check_eq("t4_srca", {30'd0, ALUSrcA}, 32'd2);
    step();
    check_eq("t4_back_fetch", {28'd0, state_o}, 32'd0);

    // T5: undefined op
    Op = 2'b11; Funct = 6'b000000;
    step();
    step();
    check_eq("t5_state", {28'd0, state_o}, 32'd10);
    pack_outs();
    check_eq("t5_outs_zero", all_outs, 32'd0);
    step();
    check_eq("t5_back_fetch", {28'd0, state_o}, 32'd0);

    // T6: STR stalled, reset asserted mid-MEMWR
    Op = 2'b01; Funct = 6'b000000;
    step();
    step();
    mem_ready = 1'b0;
    step();
    check_eq("t6_memwr_state", {28'd0, state_o}, 32'd5);
    check_eq("t6_memwr_memw", {31'd0, MemW}, 32'd1);
    check_eq("t6_memwr_req", {31'd0, mem_req}, 32'd1);
    step();
    check_eq("t6_memwr_hold", {28'd0, state_o}, 32'd5);
    #2 reset_n = 1'b0; #1;
    check_eq("t6_rst_state", {28'd0, state_o}, 32'd0);
    check_eq("t6_rst_memw", {31'd0, MemW}, 32'd0);
    check_eq("t6_rst_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check_eq("t6_rel_req", {31'd0, mem_req}, 32'd1);
    check_eq("t6_rel_irwrite", {31'd0, IRWrite}, 32'd0);

    // Ready arriving in the timeout cycle wins over the fault
    for (int i = 0; i < 16; i++) step();
    check_eq("tw_still_fetch", {28'd0, state_o}, 32'd0);
    mem_ready = 1'b1; #1;
    check_eq("tw_irwrite", {31'd0, IRWrite}, 32'd1);
    step();
    check_eq("tw_decode", {28'd0, state_o}, 32'd1);

    // T3: endless stall in FETCH ends in FAULT after 17 cycles
    mem_ready = 1'b0;
    reset_n = 1'b0; #1;
    @(negedge clk); reset_n = 1'b1; #1;
    for (int i = 0; i < 16; i++) begin
      step();
      check_eq("t3_fetch_hold", {28'd0, state_o}, 32'd0);
    end
    step();
    check_eq("t3_fault_state", {28'd0, state_o}, 32'd12);
    check_eq("t3_fault_flag", {31'd0, fault}, 32'd1);
    check_eq("t3_fault_req", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b1;
    step();
    step();
    check_eq("t3_fault_sticky", {28'd0, state_o}, 32'd12);
    check_eq("t3_fault_flag2", {31'd0, fault}, 32'd1);
    #2 reset_n = 1'b0; #1;
    check_eq("t3_rst_state", {28'd0, state_o}, 32'd0);
    check_eq("t3_rst_fault", {31'd0, fault}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
